// File: rtl/br_table_resolver_pkg.sv
// Shared constants for the br_table immediate resolver.
//   - FSM state encodings for br_table_resolver.
//   - LEB_MAX_BYTES: longest legal LEB128 encoding of a u32.
//   - clamp_index: maps an out-of-range br_table index onto the default label.
package br_table_resolver_pkg;

  localparam int unsigned LEB_MAX_BYTES = 5;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCount = 2'd1;
  localparam logic [1:0] StEntry = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  // Index of the label that will be taken: entry N is the default.
  function automatic logic [31:0] clamp_index(logic [31:0] idx, logic [31:0] n);
    return (idx < n) ? idx : n;
  endfunction

endpackage

// File: rtl/leb128_u32_acc.sv
// Byte-serial unsigned LEB128 (u32) accumulator.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clear           - discard any partial value
//   byte_valid      - byte_data holds the next encoded byte this cycle
//   byte_data [7:0] - encoded byte
//   value [31:0]    - accumulated value including byte_data; valid with complete
//   complete        - byte_data terminates a well-formed value
//   overflow        - byte_data is a 5th byte with continuation or bits 6:4 set
// The accumulator restarts by itself after complete or overflow, so it can be
// reused back-to-back for consecutive values without an explicit clear.
module leb128_u32_acc
  import br_table_resolver_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] value,
  output logic        complete,
  output logic        overflow
);

  logic [31:0] acc_q;
  logic [2:0]  n_q;
  logic [4:0]  shamt;
  logic        last_byte;

  always_comb begin
    shamt     = {2'b00, n_q} * 5'd7;
    last_byte = (n_q == 3'(LEB_MAX_BYTES - 1));
    value     = acc_q | ({25'd0, byte_data[6:0]} << shamt);
    overflow  = byte_valid & last_byte & (byte_data[7] | (|byte_data[6:4]));
    complete  = byte_valid & ~byte_data[7] & ~overflow;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      n_q   <= '0;
    end else if (clear || complete || overflow) begin
      acc_q <= '0;
      n_q   <= '0;
    end else if (byte_valid) begin
      acc_q <= value;
      n_q   <= n_q + 3'd1;
    end
  end

endmodule

// File: rtl/br_table_resolver.sv
// Sequential resolver for the WebAssembly br_table immediate.
// Walks the LEB128 label vector in ROM one byte per cycle and returns the
// selected branch depth and the address just past the table.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   start                 - one-cycle request, ignored while busy
//   table_addr            - address of the vector count byte
//   index [31:0]          - br_table operand (unsigned)
//   busy                  - walk in progress
//   done                  - one-cycle pulse, target/next_pc valid
//   error                 - sticky malformed-LEB / ROM fault flag
//   target [31:0]         - resolved label depth
//   next_pc               - address past the default label
//   mem_addr, mem_extra   - ROM request (one byte per access)
//   mem_data, mem_error   - ROM response, one cycle after the address
module br_table_resolver
  import br_table_resolver_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 6,
  parameter int unsigned MEM_EXTRA = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MEM_DEPTH:0]            table_addr,
  input  logic [31:0]                   index,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   target,
  output logic [MEM_DEPTH:0]            next_pc,
  output logic [MEM_DEPTH:0]            mem_addr,
  output logic [MEM_EXTRA-1:0]          mem_extra,
  input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
  input  logic                          mem_error
);

  localparam int unsigned DataWidth = (2**MEM_EXTRA) * 8;

  logic [1:0]         state_q, state_d;
  logic               busy_q, busy_d;
  logic               primed_q, primed_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [31:0]        target_q, target_d;
  logic [MEM_DEPTH:0] next_pc_q, next_pc_d;
  logic [MEM_DEPTH:0] mem_addr_q, mem_addr_d;
  logic [31:0]        index_q, index_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        k_q, k_d;
  logic [31:0]        entry_q, entry_d;
  logic [31:0]        sel_q, sel_d;

  logic        start_ok;
  logic        consume;
  logic        clear_acc;
  logic [31:0] leb_value;
  logic        leb_complete;
  logic        leb_overflow;

  logic unused_mem_data;
  assign unused_mem_data = ^mem_data[DataWidth-1:8];

  // The ROM answers one cycle late, so the first cycle of a walk only primes
  // the pipeline; from then on one byte is consumed every cycle.
  assign start_ok = start & ~busy_q;
  assign consume  = busy_q & primed_q;

  leb128_u32_acc u_leb (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_acc),
    .byte_valid (consume),
    .byte_data  (mem_data[7:0]),
    .value      (leb_value),
    .complete   (leb_complete),
    .overflow   (leb_overflow)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    primed_d   = primed_q;
    done_d     = 1'b0;
    error_d    = error_q;
    target_d   = target_q;
    next_pc_d  = next_pc_q;
    mem_addr_d = mem_addr_q;
    index_d    = index_q;
    count_d    = count_q;
    k_d        = k_q;
    entry_d    = entry_q;
    sel_d      = sel_q;
    clear_acc  = 1'b0;

    if (start_ok) begin
      state_d    = StCount;
      busy_d     = 1'b1;
      primed_d   = 1'b0;
      error_d    = 1'b0;
      index_d    = index;
      mem_addr_d = table_addr;
      clear_acc  = 1'b1;
    end else if (busy_q) begin
      primed_d   = 1'b1;
      mem_addr_d = mem_addr_q + {{MEM_DEPTH{1'b0}}, 1'b1};
      if (consume) begin
        if (mem_error || leb_overflow) begin
          state_d    = StFault;
          busy_d     = 1'b0;
          error_d    = 1'b1;
          mem_addr_d = mem_addr_q;
        end else if (leb_complete) begin
          case (state_q)
            StCount: begin
              count_d = leb_value;
              k_d     = clamp_index(index_q, leb_value);
              entry_d = '0;
              state_d = StEntry;
            end
            StEntry: begin
              // Selected label is staged in sel_q so target only moves on done.
              if (entry_q == k_q) sel_d = leb_value;
              if (entry_q == count_q) begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
                // mem_addr already points one past the byte being consumed.
                next_pc_d  = mem_addr_q;
                mem_addr_d = mem_addr_q;
                target_d   = (entry_q == k_q) ? leb_value : sel_q;
              end else begin
                entry_d = entry_q + 32'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      primed_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      target_q   <= '0;
      next_pc_q  <= '0;
      mem_addr_q <= '0;
      index_q    <= '0;
      count_q    <= '0;
      k_q        <= '0;
      entry_q    <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      primed_q   <= primed_d;
      done_q     <= done_d;
      error_q    <= error_d;
      target_q   <= target_d;
      next_pc_q  <= next_pc_d;
      mem_addr_q <= mem_addr_d;
      index_q    <= index_d;
      count_q    <= count_d;
      k_q        <= k_d;
      entry_q    <= entry_d;
      sel_q      <= sel_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign target    = target_q;
  assign next_pc   = next_pc_q;
  assign mem_addr  = mem_addr_q;
  assign mem_extra = '0;

endmodule

// File: tb/tb_br_table_resolver.sv
// Self-checking bench for br_table_resolver: directed tables plus random tables
// checked against a byte-walking reference model of the br_table immediate.
module tb_br_table_resolver;

  localparam int unsigned MEM_DEPTH = 6;
  localparam int unsigned MEM_EXTRA = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [6:0]   table_addr;
  logic [31:0]  index;
  logic         busy, done, error;
  logic [31:0]  target;
  logic [6:0]   next_pc, mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data;
  logic         mem_error;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rom [128];
  logic [7:0]  tbl [$];
  int          merr_off;
  bit          merr_en;
  logic [6:0]  merr_a;
  logic [31:0] last_target;
  logic [6:0]  last_pc;

  br_table_resolver #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .table_addr (table_addr),
    .index      (index),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .target     (target),
    .next_pc    (next_pc),
    .mem_addr   (mem_addr),
    .mem_extra  (mem_extra),
    .mem_data   (mem_data),
    .mem_error  (mem_error)
  );

  always #5 clk = ~clk;

  // Registered ROM: junk in the unused upper lanes.
  always @(posedge clk) begin
    mem_data  <= {$urandom(), $urandom(), $urandom(), 24'($urandom()), rom[mem_addr]};
    mem_error <= merr_en && (mem_addr == merr_a);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_leb(input logic [31:0] v, input int len);
    logic [7:0] b;
    for (int n = 0; n < len; n++) begin
      b = 8'((v >> (7 * n)) & 32'h7f);
      if (n < len - 1) b = b | 8'h80;
      tbl.push_back(b);
    end
  endtask

  // Decode one LEB128 u32 from tbl starting at pos.
  task automatic leb(inout int pos, output logic [63:0] v, inout bit bad, inout int epos);
    logic [7:0] b;
    v = 0;
    for (int n = 0; n < 5; n++) begin
      b = tbl[pos];
      if (pos == merr_off || (n == 4 && b >= 8'h10)) begin
        bad  = 1;
        epos = pos;
        pos++;
        return;
      end
      pos++;
      v = v + 64'(b % 128) * (64'd1 << (7 * n));
      if (b < 128) return;
    end
  endtask

  task automatic model(input logic [31:0] idx, output logic [31:0] tgt, output int nb,
                       output bit bad, output int epos);
    int pos;
    logic [63:0] v, cnt, k;
    pos  = 0;
    bad  = 0;
    epos = 0;
    tgt  = last_target;
    leb(pos, v, bad, epos);
    if (!bad) begin
      cnt = v;
      k   = ({32'd0, idx} < cnt) ? {32'd0, idx} : cnt;
      for (logic [63:0] e = 0; e <= cnt && !bad; e++) begin
        leb(pos, v, bad, epos);
        if (!bad && e == k) tgt = v[31:0];
      end
    end
    nb = pos;
  endtask

  task automatic walk(input string tag, input logic [6:0] a, input logic [31:0] idx,
                      input int stray);
    logic [31:0] tgt;
    int nb, epos, end_e, done_e, err_e, done_cnt, limit;
    bit bad, busy_ok;
    model(idx, tgt, nb, bad, epos);
    foreach (tbl[i]) rom[7'(a + 7'(i))] = tbl[i];
    merr_en = (merr_off >= 0);
    merr_a  = 7'(a + 7'(merr_off));
    end_e   = bad ? epos + 2 : nb + 1;
    @(negedge clk);
    start = 1'b1;
    table_addr = a;
    index = idx;
    @(posedge clk);
    #1;
    start = 1'b0;
    index = $urandom();
    table_addr = 7'($urandom());
    done_e = 0; err_e = 0; done_cnt = 0; busy_ok = 1;
    limit = nb + 8;
    for (int e = 1; e <= limit; e++) begin
      if (e == stray) begin
        start = 1'b1;
        index = ~idx;
        table_addr = a + 7'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_e == 0) done_e = e;
      end
      if (error && err_e == 0) err_e = e;
      if (e < end_e && !busy) busy_ok = 0;
      if (e == end_e && busy) busy_ok = 0;
    end
    chk({tag, " busy_window"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    if (!bad) begin
      chk({tag, " done_edge"}, 64'(done_e), 64'(end_e));
      chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, " target"}, 64'(target), 64'(tgt));
      chk({tag, " next_pc"}, 64'(next_pc), 64'(7'(a + 7'(nb))));
      chk({tag, " error"}, 64'(error), 64'd0);
      last_target = tgt;
      last_pc = 7'(a + 7'(nb));
    end else begin
      chk({tag, " error_edge"}, 64'(err_e), 64'(end_e));
      chk({tag, " error"}, 64'(error), 64'd1);
      chk({tag, " no_done"}, 64'(done_cnt), 64'd0);
      chk({tag, " target_kept"}, 64'(target), 64'(last_target));
      chk({tag, " next_pc_kept"}, 64'(next_pc), 64'(last_pc));
    end
    merr_off = -1;
    merr_en = 0;
  endtask

  task automatic set_tbl4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3);
    tbl.delete();
    tbl.push_back(b0);
    tbl.push_back(b1);
    tbl.push_back(b2);
    tbl.push_back(b3);
  endtask

  initial begin
    int n, len;
    logic [31:0] v, idx;
    reset = 1'b0;
    start = 1'b0;
    table_addr = '0;
    index = '0;
    merr_off = -1;
    merr_en = 0;
    merr_a = '0;
    last_target = '0;
    last_pc = '0;
    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom());

    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst target", 64'(target), 64'd0);
    chk("rst next_pc", 64'(next_pc), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_extra", 64'(mem_extra), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    set_tbl4(8'h02, 8'h05, 8'h03, 8'h07);
    walk("t1_idx1", 7'h10, 32'd1, 0);
    walk("t2_idx9", 7'h10, 32'd9, 0);
    set_tbl4(8'h01, 8'h80, 8'h01, 8'h7f);
    walk("t3_two_byte", 7'h30, 32'd0, 0);
    tbl.delete();
    tbl.push_back(8'h00);
    tbl.push_back(8'h04);
    walk("t4_n0", 7'h22, 32'hffff_ffff, 0);
    tbl.delete();
    tbl.push_back(8'h01);
    repeat (4) tbl.push_back(8'hff);
    tbl.push_back(8'h7f);
    walk("t5_malformed", 7'h40, 32'd0, 0);
    set_tbl4(8'h02, 8'h05, 8'h03, 8'h07);
    walk("t6_recover_stray", 7'h10, 32'd0, 2);
    set_tbl4(8'h02, 8'h05, 8'h03, 8'h07);
    merr_off = 2;
    walk("t7_mem_error", 7'h50, 32'd1, 0);

    // Asynchronous reset in the middle of a walk.
    set_tbl4(8'h02, 8'h05, 8'h03, 8'h07);
    walk("t8_pre_reset", 7'h60, 32'd2, 0);
    @(negedge clk);
    start = 1'b1;
    table_addr = 7'h10;
    index = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst error", 64'(error), 64'd0);
    chk("arst target", 64'(target), 64'd0);
    chk("arst next_pc", 64'(next_pc), 64'd0);
    chk("arst mem_addr", 64'(mem_addr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    last_target = '0;
    last_pc = '0;
    repeat (8) @(negedge clk);
    chk("post_rst idle busy", 64'(busy), 64'd0);
    chk("post_rst idle mem_addr", 64'(mem_addr), 64'd0);
    walk("t9_after_reset", 7'h10, 32'd0, 0);

    for (int r = 0; r < 20; r++) begin
      tbl.delete();
      n = $urandom_range(0, 4);
      push_leb(32'(n), $urandom_range(1, 2));
      for (int e = 0; e <= n; e++) begin
        len = $urandom_range(1, 5);
        v = $urandom();
        if (len < 5) v = v & ((32'd1 << (7 * len)) - 32'd1);
        push_leb(v, len);
      end
      idx = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, n + 1));
      if (r % 5 == 4) merr_off = $urandom_range(0, tbl.size() - 1);
      walk($sformatf("rand%0d", r), 7'($urandom_range(0, 90)), idx, (r % 3 == 0) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
